// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH..WB sequencer for the multicycle MIPS datapath, with a DataMem ready
// handshake and timeout watchdog. Define MC_PERF_CNT_EN to add cycle_cnt/inst_cnt outputs.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_rdy,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic       EXTOp,
  output logic [1:0] RegDst,
  output logic [1:0] RegSrc,
  output logic [1:0] NPCOp,
  output logic [3:0] state,
  output logic       illegal,
  output logic       mem_err
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
`endif
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC   = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWR  = 4'd4;
  localparam logic [3:0] S_ALUWB  = 4'd5;
  localparam logic [3:0] S_LDWB   = 4'd6;
  localparam logic [3:0] S_BRANCH = 4'd7;
  localparam logic [3:0] S_JUMP   = 4'd8;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
    $error("multicycle_ctrl: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, mem_err_q;
  logic              set_ill, set_err;
  logic              timeout;

  logic is_alu, is_lw, is_sw, is_beq, is_j, is_jal, is_jr, is_jmp;
  logic       alu_src, ext_op;
  logic [2:0] alu_op;
  logic [1:0] reg_dst, reg_src;
  logic       pc_wr, ir_wr, reg_wr, mem_wr;
  logic [1:0] npc_op;

  // Datapath selects are a pure function of the instruction held in InsReg.
  always_comb begin
    is_alu  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    ext_op  = 1'b1;
    reg_dst = 2'b00;
    reg_src = 2'b00;
    case (opcode)
      OP_R: begin
        reg_dst = 2'b01;
        case (funct)
          FN_ADDU: is_alu = 1'b1;
          FN_SUBU: begin is_alu = 1'b1; alu_op = ALU_SUB; end
          FN_AND:  begin is_alu = 1'b1; alu_op = ALU_AND; end
          FN_OR:   begin is_alu = 1'b1; alu_op = ALU_OR;  end
          FN_SLT:  begin is_alu = 1'b1; alu_op = ALU_SLT; end
          FN_JR:   is_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDIU: begin is_alu = 1'b1; alu_src = 1'b1; end
      OP_ORI:   begin is_alu = 1'b1; alu_src = 1'b1; alu_op = ALU_OR; ext_op = 1'b0; end
      OP_LW:    begin is_lw = 1'b1; alu_src = 1'b1; reg_src = 2'b01; end
      OP_SW:    begin is_sw = 1'b1; alu_src = 1'b1; end
      OP_BEQ:   begin is_beq = 1'b1; alu_op = ALU_SUB; end
      OP_J:     is_j = 1'b1;
      OP_JAL:   begin is_jal = 1'b1; reg_dst = 2'b10; reg_src = 2'b10; end
      default: ;
    endcase
  end

  assign is_jmp  = is_j | is_jal | is_jr;
  assign timeout = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Memory handshake: the request (MEMRD state / MemWrite) is held every cycle until mem_rdy
  // is high at a rising edge; that edge completes the transfer. mem_rdy wins over timeout.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    reg_wr  = 1'b0;
    mem_wr  = 1'b0;
    npc_op  = 2'b00;
    set_ill = 1'b0;
    set_err = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu || is_lw || is_sw) state_d = S_EXEC;
        else if (is_beq)              state_d = S_BRANCH;
        else if (is_jmp)              state_d = S_JUMP;
        else begin
          pc_wr   = 1'b1;
          set_ill = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_lw)      state_d = S_MEMRD;
        else if (is_sw) state_d = S_MEMWR;
        else            state_d = S_ALUWB;
      end
      S_MEMRD: begin
        if (mem_rdy) state_d = S_LDWB;
        else if (timeout) begin
          pc_wr   = 1'b1;
          set_err = 1'b1;
          state_d = S_FETCH;
        end else wait_d = wait_q + WAIT_W'(1);
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        if (mem_rdy) begin
          pc_wr   = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          pc_wr   = 1'b1;
          set_err = 1'b1;
          state_d = S_FETCH;
        end else wait_d = wait_q + WAIT_W'(1);
      end
      S_ALUWB, S_LDWB: begin
        reg_wr  = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        pc_wr   = 1'b1;
        npc_op  = Zero ? 2'b01 : 2'b00;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_wr   = 1'b1;
        npc_op  = is_jr ? 2'b11 : 2'b10;
        reg_wr  = is_jal;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (set_ill) illegal_q <= 1'b1;
      if (set_err) mem_err_q <= 1'b1;
    end
  end

  // Gating with rst makes every output drop in the same instant reset asserts.
  assign PCWr     = rst & pc_wr;
  assign IRWr     = rst & ir_wr;
  assign RegWrite = rst & reg_wr;
  assign MemWrite = rst & mem_wr;
  assign ALUSrc   = rst & alu_src;
  assign EXTOp    = rst & ext_op;
  assign ALUOp    = rst ? alu_op  : 3'b000;
  assign RegDst   = rst ? reg_dst : 2'b00;
  assign RegSrc   = rst ? reg_src : 2'b00;
  assign NPCOp    = rst ? npc_op  : 2'b00;
  assign state    = state_q;
  assign illegal  = illegal_q;
  assign mem_err  = mem_err_q;

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (pc_wr) inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomised sequences for multicycle_ctrl; one expected
// end-of-instruction record is queued per instruction and compared at its PCWr cycle.
module tb_multicycle_ctrl;

  localparam int MT = 16;
  localparam int W  = 20;

  logic       clk, rst;
  logic [5:0] opcode, funct;
  logic       Zero, mem_rdy;
  logic       PCWr, IRWr, RegWrite, MemWrite, ALUSrc, EXTOp;
  logic [2:0] ALUOp;
  logic [1:0] RegDst, RegSrc, NPCOp;
  logic [3:0] state;
  logic       illegal, mem_err;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, inst_cnt;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero), .mem_rdy(mem_rdy),
    .PCWr(PCWr), .IRWr(IRWr), .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .EXTOp(EXTOp), .RegDst(RegDst), .RegSrc(RegSrc), .NPCOp(NPCOp),
    .state(state), .illegal(illegal), .mem_err(mem_err)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // monitor results of the last run_inst
  logic [63:0] trace_w;
  int          n_irwr, n_rw, n_memwr;
  logic        sel_changed;

  logic [5:0] t_op [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h0D,
                            6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h00};
  logic [5:0] t_fn [13] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h11, 6'h05,
                            6'h21, 6'h3F, 6'h00, 6'h15, 6'h2A, 6'h08};

  function automatic logic [W-1:0] pack(input int cyc, input logic [1:0] npc, input logic rw,
                                        input logic [1:0] rdst, input logic [1:0] rsrc,
                                        input logic [2:0] aop, input logic asrc, input logic ext);
    logic [7:0] c8;
    c8 = cyc[7:0];
    return {c8, npc, rw, rdst, rsrc, aop, asrc, ext};
  endfunction

  // Expected end-of-instruction record; d = mem_rdy low cycles before it rises (>= MT: never).
  function automatic logic [W-1:0] model(input logic [5:0] op, input logic [5:0] fn,
                                         input logic z, input int d);
    int cyc; logic [1:0] npc, rdst, rsrc; logic rw, asrc, ext; logic [2:0] aop;
    cyc = 4; npc = 2'b00; rw = 1'b1; rdst = (op == 6'h00) ? 2'b01 : 2'b00;
    rsrc = 2'b00; aop = 3'b000; asrc = 1'b0; ext = 1'b1;
    case (op)
      6'h00: case (fn)
        6'h21: ;
        6'h23: aop = 3'b001;
        6'h24: aop = 3'b010;
        6'h25: aop = 3'b011;
        6'h2A: aop = 3'b100;
        6'h08: begin cyc = 3; npc = 2'b11; rw = 1'b0; end
        default: begin cyc = 2; rw = 1'b0; end
      endcase
      6'h09: asrc = 1'b1;
      6'h0D: begin asrc = 1'b1; aop = 3'b011; ext = 1'b0; end
      6'h23: begin asrc = 1'b1; rsrc = 2'b01; cyc = (d >= MT) ? 3 + MT : 5 + d; rw = (d < MT); end
      6'h2B: begin asrc = 1'b1; cyc = (d >= MT) ? 3 + MT : 4 + d; rw = 1'b0; end
      6'h04: begin cyc = 3; rw = 1'b0; aop = 3'b001; npc = z ? 2'b01 : 2'b00; end
      6'h02: begin cyc = 3; rw = 1'b0; npc = 2'b10; end
      6'h03: begin cyc = 3; npc = 2'b10; rdst = 2'b10; rsrc = 2'b10; end
      default: begin cyc = 2; rw = 1'b0; end
    endcase
    return pack(cyc, npc, rw, rdst, rsrc, aop, asrc, ext);
  endfunction

  // driver/monitor: starts in the low clock phase with state FETCH, returns at the next one.
  task automatic run_inst(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int d, output logic [W-1:0] obs);
    int memcnt;
    logic [8:0] sel_dec;
    memcnt = 0; sel_dec = '0; obs = '1;
    trace_w = '0; n_irwr = 0; n_rw = 0; n_memwr = 0; sel_changed = 1'b0;
    opcode = op; funct = fn;
    for (int c = 1; c <= 64; c++) begin
      if (state == 4'd3 || state == 4'd4) begin
        mem_rdy = (memcnt >= d);
        memcnt++;
      end else mem_rdy = 1'($urandom_range(0, 1));
      Zero = (state == 4'd7) ? z : 1'($urandom_range(0, 1));
      #1;
      trace_w = {trace_w[59:0], state};
      if (IRWr) n_irwr++;
      if (RegWrite) n_rw++;
      if (MemWrite) n_memwr++;
      if (state == 4'd1) sel_dec = {ALUSrc, ALUOp, EXTOp, RegDst, RegSrc};
      else if (state != 4'd0 && {ALUSrc, ALUOp, EXTOp, RegDst, RegSrc} !== sel_dec)
        sel_changed = 1'b1;
      if (PCWr) begin
        obs = pack(c, NPCOp, RegWrite, RegDst, RegSrc, ALUOp, ALUSrc, EXTOp);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; opcode = 6'h00; funct = 6'h21; Zero = 1'b1; mem_rdy = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({PCWr, IRWr, RegWrite, MemWrite} !== 4'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b expected 0000", {PCWr, IRWr, RegWrite, MemWrite});
    end
    n_cmp++;
    if ({ALUSrc, ALUOp, EXTOp, RegDst, RegSrc, NPCOp} !== 11'b0) begin
      n_err++; $display("FAIL reset_selects: got %h expected 000", {ALUSrc, ALUOp, EXTOp, RegDst, RegSrc, NPCOp});
    end
    n_cmp++;
    if ({state, illegal, mem_err} !== 6'b0) begin
      n_err++; $display("FAIL reset_state: got %h expected 00", {state, illegal, mem_err});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({state, IRWr} !== 5'b0000_1) begin
      n_err++; $display("FAIL reset_release: got %h expected 01", {state, IRWr});
    end
  endtask

  task automatic test_alu();
    logic [W-1:0] obs, e;
    exp_q.push_back(pack(4, 2'b00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b1));
    run_inst(6'h00, 6'h21, 1'b0, 0, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL addu: got %h expected %h", obs, e); end
    n_cmp++;
    if ({trace_w, n_irwr[3:0], n_rw[3:0]} !== {64'h0125, 4'd1, 4'd1}) begin
      n_err++; $display("FAIL addu_trace: got %h/%0d/%0d expected 0125/1/1", trace_w, n_irwr, n_rw);
    end
    for (int i = 1; i < 7; i++) begin
      exp_q.push_back(model(t_op[i], t_fn[i], 1'b0, 0));
      run_inst(t_op[i], t_fn[i], 1'b0, 0, obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e || sel_changed) begin
        n_err++; $display("FAIL alu_%0d: got %h sel_changed %b expected %h", i, obs, sel_changed, e);
      end
    end
  endtask

  task automatic test_load();
    logic [W-1:0] obs, e;
    exp_q.push_back(pack(8, 2'b00, 1'b1, 2'b00, 2'b01, 3'b000, 1'b1, 1'b1));
    run_inst(6'h23, 6'h00, 1'b0, 3, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL lw_wait3: got %h expected %h", obs, e); end
    n_cmp++;
    if (trace_w !== 64'h0123_3336 || sel_changed) begin
      n_err++; $display("FAIL lw_trace: got %h sel_changed %b expected 01233336", trace_w, sel_changed);
    end
    exp_q.push_back(model(6'h23, 6'h00, 1'b0, 0));
    run_inst(6'h23, 6'h00, 1'b0, 0, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL lw_nowait: got %h expected %h", obs, e); end
  endtask

  task automatic test_store();
    logic [W-1:0] obs, e;
    exp_q.push_back(model(6'h2B, 6'h00, 1'b0, 0));
    run_inst(6'h2B, 6'h00, 1'b0, 0, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e || n_memwr != 1) begin
      n_err++; $display("FAIL sw_nowait: got %h memwr %0d expected %h memwr 1", obs, n_memwr, e);
    end
    // mem_rdy arrives on the very cycle the count reaches MT-1: normal completion
    exp_q.push_back(pack(3 + MT, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1));
    run_inst(6'h2B, 6'h00, 1'b0, MT - 1, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e || n_memwr != MT || mem_err !== 1'b0) begin
      n_err++; $display("FAIL sw_last_cycle_rdy: got %h memwr %0d mem_err %b expected %h %0d 0",
                        obs, n_memwr, mem_err, e, MT);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] obs, e;
    exp_q.push_back(pack(3 + MT, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1));
    run_inst(6'h2B, 6'h00, 1'b0, 1000, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e || n_memwr != MT) begin
      n_err++; $display("FAIL sw_timeout: got %h memwr %0d expected %h memwr %0d", obs, n_memwr, e, MT);
    end
    n_cmp++;
    if ({mem_err, state} !== 5'b1_0000) begin
      n_err++; $display("FAIL sw_timeout_flag: got %h expected 10", {mem_err, state});
    end
    exp_q.push_back(model(6'h23, 6'h00, 1'b0, 1000));
    run_inst(6'h23, 6'h00, 1'b0, 1000, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e || n_rw != 0 || mem_err !== 1'b1) begin
      n_err++; $display("FAIL lw_timeout: got %h rw %0d mem_err %b expected %h 0 1", obs, n_rw, mem_err, e);
    end
  endtask

  task automatic test_branch();
    logic [W-1:0] obs, e;
    for (int z = 1; z >= 0; z--) begin
      exp_q.push_back(pack(3, z[0] ? 2'b01 : 2'b00, 1'b0, 2'b00, 2'b00, 3'b001, 1'b0, 1'b1));
      run_inst(6'h04, 6'h00, z[0], 0, obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL beq_zero%0d: got %h expected %h", z, obs, e); end
    end
  endtask

  task automatic test_jump();
    logic [W-1:0] obs, e;
    exp_q.push_back(pack(3, 2'b10, 1'b1, 2'b10, 2'b10, 3'b000, 1'b0, 1'b1));
    run_inst(6'h03, 6'h00, 1'b0, 0, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL jal: got %h expected %h", obs, e); end
    exp_q.push_back(pack(3, 2'b11, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 1'b1));
    run_inst(6'h00, 6'h08, 1'b0, 0, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e || n_rw != 0) begin n_err++; $display("FAIL jr: got %h rw %0d expected %h 0", obs, n_rw, e); end
    exp_q.push_back(model(6'h02, 6'h00, 1'b0, 0));
    run_inst(6'h02, 6'h00, 1'b0, 0, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL j: got %h expected %h", obs, e); end
  endtask

  task automatic test_illegal();
    logic [W-1:0] obs, e;
    n_cmp++;
    if (illegal !== 1'b0) begin n_err++; $display("FAIL illegal_before: got %b expected 0", illegal); end
    exp_q.push_back(pack(2, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1));
    run_inst(6'h3F, 6'h00, 1'b0, 0, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e || illegal !== 1'b1) begin
      n_err++; $display("FAIL illegal_op3f: got %h illegal %b expected %h 1", obs, illegal, e);
    end
    exp_q.push_back(model(6'h00, 6'h3F, 1'b0, 0));
    run_inst(6'h00, 6'h3F, 1'b0, 0, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL illegal_funct: got %h expected %h", obs, e); end
    exp_q.push_back(model(6'h00, 6'h21, 1'b0, 0));
    run_inst(6'h00, 6'h21, 1'b0, 0, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e || illegal !== 1'b1) begin
      n_err++; $display("FAIL illegal_sticky: got %h illegal %b expected %h 1", obs, illegal, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] obs, e;
    logic any_sel;
    int idx, d;
    logic z;
    any_sel = 1'b0;
    for (int n = 0; n < 30; n++) begin
      idx = $urandom_range(0, 12);
      z   = 1'($urandom_range(0, 1));
      d   = ($urandom_range(0, 5) == 0) ? 100 : $urandom_range(0, 4);
      exp_q.push_back(model(t_op[idx], t_fn[idx], z, d));
      run_inst(t_op[idx], t_fn[idx], z, d, obs);
      any_sel = any_sel | sel_changed;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL b2b_%0d op %h fn %h z %b d %0d: got %h expected %h",
                          n, t_op[idx], t_fn[idx], z, d, obs, e);
      end
    end
    n_cmp++;
    if (any_sel !== 1'b0) begin n_err++; $display("FAIL b2b_selects_held: got 1 expected 0"); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] obs, e;
    opcode = 6'h00; funct = 6'h21; mem_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (state !== 4'd2) begin n_err++; $display("FAIL rst_mid_exec: got %0d expected 2", state); end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({state, PCWr, IRWr, RegWrite, MemWrite, illegal, mem_err} !== 10'b0) begin
      n_err++; $display("FAIL rst_mid_async: got %h expected 000",
                        {state, PCWr, IRWr, RegWrite, MemWrite, illegal, mem_err});
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(model(6'h00, 6'h21, 1'b0, 0));
    run_inst(6'h00, 6'h21, 1'b0, 0, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e || trace_w !== 64'h0125) begin
      n_err++; $display("FAIL rst_mid_recover: got %h trace %h expected %h trace 0125", obs, trace_w, e);
    end
`ifdef MC_PERF_CNT_EN
    n_cmp++;
    if (inst_cnt !== 32'd1) begin n_err++; $display("FAIL perf_inst_cnt: got %0d expected 1", inst_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_branch();
    test_jump();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
